branch_unit: RTL

BRANCH_UNIT -- requirements
Module: branch_unit

---
 rtl/branch_pkg.sv | 32 +++
 rtl/branch_cond.sv | 44 ++++
 rtl/branch_unit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch unit: op encoding, FSM state type and
// target-select codes used between branch_cond and branch_unit.
package branch_pkg;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_J    = 3'b001;
    localparam logic [2:0] OP_BEQ  = 3'b010;
    localparam logic [2:0] OP_BGEZ = 3'b011;
    localparam logic [2:0] OP_BRN  = 3'b100;
    localparam logic [2:0] OP_JM   = 3'b101;
    localparam logic [2:0] OP_BALZ = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_REL  = 2'd1,
        SEL_RS   = 2'd2,
        SEL_JT   = 2'd3
    } tgt_sel_t;

    // Ops that count as branch activity: everything except none and illegal.
    function automatic logic is_branch_op(input logic [2:0] op);
        return (op != OP_NONE) && (op != OP_ILL);
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition decode: maps (op, Z, N) to taken and the
// source of the redirect target. jm is resolved by the FSM, not here.
module branch_cond
    import branch_pkg::*;
(
    input  logic [2:0] op,
    input  logic       z,
    input  logic       n,
    output logic       taken,
    output tgt_sel_t   tgt_sel
);

    always_comb begin
        taken   = 1'b0;
        tgt_sel = SEL_NONE;
        case (op)
            OP_J: begin
                taken   = 1'b1;
                tgt_sel = SEL_JT;
            end
            OP_BEQ: begin
                taken   = z;
                tgt_sel = SEL_REL;
            end
            OP_BGEZ: begin
                taken   = ~n;
                tgt_sel = SEL_REL;
            end
            OP_BRN: begin
                taken   = n;
                tgt_sel = SEL_RS;
            end
            OP_BALZ: begin
                taken   = z;
                tgt_sel = SEL_REL;
            end
            default: begin
                taken   = 1'b0;
                tgt_sel = SEL_NONE;
            end
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Branch unit: evaluates control-flow ops against the Z/N status flags, issues a
// registered PC redirect, and fetches jm targets from memory. Optional
// performance counters are built only when BRANCH_PERF_CNT_EN is defined.
module branch_unit
    import branch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int OFF_W  = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic              flag_we,
    input  logic              alu_zero,
    input  logic              alu_neg,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] rs_val,
    input  logic [ADDR_W-1:0] jtarget,
    input  logic [OFF_W-1:0]  imm,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [ADDR_W-1:0] mem_rdata,
    output logic              pc_load,
    output logic [ADDR_W-1:0] next_pc,
    output logic              taken,
    output logic              link_we,
    output logic [ADDR_W-1:0] link_data,
    output logic              busy,
    output logic              ill_op,
    output logic [CNT_W-1:0]  br_cnt,
    output logic [CNT_W-1:0]  tk_cnt
);

    state_t            state_q, state_d;
    logic              z_q, z_d, n_q, n_d;
    logic              pc_load_q, pc_load_d;
    logic              taken_q, taken_d;
    logic              link_we_q, link_we_d;
    logic              ill_op_q, ill_op_d;
    logic [ADDR_W-1:0] next_pc_q, next_pc_d;
    logic [ADDR_W-1:0] link_data_q, link_data_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    logic              z_eff, n_eff;
    logic              cond_taken;
    tgt_sel_t          tgt_sel;
    logic [ADDR_W-1:0] pc_plus4, imm_sext, rel_target, target;
    logic              accept;

    // Flags written this cycle are forwarded into the same-cycle evaluation.
    assign z_eff = flag_we ? alu_zero : z_q;
    assign n_eff = flag_we ? alu_neg  : n_q;

    assign pc_plus4   = pc + ADDR_W'(4);
    assign imm_sext   = ADDR_W'($signed(imm));
    assign rel_target = pc_plus4 + (imm_sext << 2);
    assign accept     = op_valid && (state_q == IDLE);

    branch_cond u_cond (
        .op      (op),
        .z       (z_eff),
        .n       (n_eff),
        .taken   (cond_taken),
        .tgt_sel (tgt_sel)
    );

    always_comb begin
        case (tgt_sel)
            SEL_REL: target = rel_target;
            SEL_RS:  target = rs_val;
            SEL_JT:  target = jtarget;
            default: target = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        z_d         = z_q;
        n_d         = n_q;
        pc_load_d   = 1'b0;
        taken_d     = 1'b0;
        link_we_d   = 1'b0;
        ill_op_d    = 1'b0;
        next_pc_d   = next_pc_q;
        link_data_d = link_data_q;
        mem_addr_d  = mem_addr_q;

        if (flag_we) begin
            z_d = alu_zero;
            n_d = alu_neg;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op == OP_JM) begin
                        state_d    = MEM_WAIT;
                        mem_addr_d = rs_val;
                    end else if (op == OP_ILL) begin
                        ill_op_d = 1'b1;
                    end else if (op != OP_NONE) begin
                        if (cond_taken) begin
                            pc_load_d = 1'b1;
                            taken_d   = 1'b1;
                            next_pc_d = target;
                        end
                        // balz links whether or not the branch goes.
                        if (op == OP_BALZ) begin
                            link_we_d   = 1'b1;
                            link_data_d = pc_plus4;
                        end
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    state_d   = REDIRECT;
                    pc_load_d = 1'b1;
                    taken_d   = 1'b1;
                    next_pc_d = mem_rdata;
                end
            end
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            pc_load_q   <= 1'b0;
            taken_q     <= 1'b0;
            link_we_q   <= 1'b0;
            ill_op_q    <= 1'b0;
            next_pc_q   <= '0;
            link_data_q <= '0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            z_q         <= z_d;
            n_q         <= n_d;
            pc_load_q   <= pc_load_d;
            taken_q     <= taken_d;
            link_we_q   <= link_we_d;
            ill_op_q    <= ill_op_d;
            next_pc_q   <= next_pc_d;
            link_data_q <= link_data_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    assign mem_req   = (state_q == MEM_WAIT);
    assign busy      = (state_q != IDLE);
    assign mem_addr  = mem_addr_q;
    assign pc_load   = pc_load_q;
    assign taken     = taken_q;
    assign next_pc   = next_pc_q;
    assign link_we   = link_we_q;
    assign link_data = link_data_q;
    assign ill_op    = ill_op_q;

`ifdef BRANCH_PERF_CNT_EN
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] tk_cnt_q, tk_cnt_d;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        br_cnt_d = br_cnt_q;
        tk_cnt_d = tk_cnt_q;
        if (accept && is_branch_op(op) && (br_cnt_q != '1))
            br_cnt_d = br_cnt_q + CNT_W'(1);
        if (taken_d && (tk_cnt_q != '1))
            tk_cnt_d = tk_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            br_cnt_q <= '0;
            tk_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
            tk_cnt_q <= tk_cnt_d;
        end
    end

    assign br_cnt = br_cnt_q;
    assign tk_cnt = tk_cnt_q;
`else
    assign br_cnt = '0;
    assign tk_cnt = '0;
`endif

endmodule
